// File: rtl/hls_ip_multi_ch_ctrl_if.sv
// Peripheral register-access bus between the interconnect and the job controller.
// The interconnect side is the master and the controller side is the slave.
interface hls_ip_multi_ch_ctrl_if;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output req, we, addr, wdata, input  gnt, rdata, rvalid);
    modport slave  (input  req, we, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/hls_ip_multi_ch_ctrl.sv
// Job controller for HLS accelerators: memory-mapped register file, per-channel beat
// counting and a start/run/done sequencer that raises a completion event per core.
module hls_ip_multi_ch_ctrl #(
    parameter  int N_IN_CH   = 1,
    parameter  int N_OUT_CH  = 1,
    parameter  int CNT_WIDTH = 16,
    parameter  int N_CORES   = 2,
    localparam int N_CH      = N_IN_CH + N_OUT_CH,
    localparam int CW        = CNT_WIDTH + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hls_ip_multi_ch_ctrl_if.slave periph,
    input  logic [N_CH-1:0]      ch_valid_i,
    input  logic [N_CH-1:0]      ch_ready_i,
    output logic [N_CH-1:0]      ch_start_o,
    output logic [N_CH*CW-1:0]   ch_len_o,
    output logic [7:0]           op_type_o,
    output logic                 busy_o,
    output logic [N_CORES-1:0]   evt_o
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_START, S_RUN, S_DONE} state_t;

    state_t               r_state;
    logic                 r_busy, r_start, r_evt, r_done, r_err, r_rvalid;
    logic [31:0]          r_rdata;
    logic [7:0]           r_op_type;
    logic [N_CH-1:0]      r_ready;
    logic [CNT_WIDTH-1:0] r_len [N_CH];
    logic [CW-1:0]        r_cnt [N_CH];

    logic [CW-1:0]        w_len_eff [N_CH];
    logic [CW-1:0]        w_cnt_nxt [N_CH];
    logic                 w_wr, w_rd, w_trig, w_op_wr, w_ready_wr, w_clr, w_len_wr, w_prog_rd;
    logic                 w_counting, w_ovf, w_all_done;
    logic [2:0]           w_idx;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_wr       = periph.req &  periph.we;
    assign w_rd       = periph.req & ~periph.we;
    assign w_idx      = periph.addr[4:2];
    assign w_trig     = w_wr && (periph.addr == 8'h00);
    assign w_op_wr    = w_wr && (periph.addr == 8'h08);
    assign w_ready_wr = w_wr && (periph.addr == 8'h0C);
    assign w_clr      = w_wr && (periph.addr == 8'h18);
    assign w_len_wr   = w_wr && (periph.addr[7:5] == 3'b001) && (periph.addr[1:0] == 2'b00);
    assign w_prog_rd  = (periph.addr[7:5] == 3'b010) && (periph.addr[1:0] == 2'b00);
    assign w_counting = (r_state == S_START) || (r_state == S_RUN);
    assign w_unused   = ^{periph.wdata, periph.addr};

    // Effective length is LEN+1 at one bit wider, so an all-ones LEN yields 2^CNT_WIDTH.
    for (genvar c = 0; c < N_CH; c++) begin : g_len
        assign w_len_eff[c]          = {1'b0, r_len[c]} + CW'(1);
        assign ch_len_o[c*CW +: CW]  = w_len_eff[c];
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_ovf      = 1'b0;
        w_all_done = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            w_cnt_nxt[c] = r_cnt[c];
            if (w_counting && ch_valid_i[c] && ch_ready_i[c]) begin
                if (r_cnt[c] >= w_len_eff[c]) w_ovf = 1'b1;
                else                          w_cnt_nxt[c] = r_cnt[c] + CW'(1);
            end
            if (w_cnt_nxt[c] != w_len_eff[c]) w_all_done = 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (periph.addr)
            8'h04:   w_rdata = {29'b0, r_err, r_done, r_busy};
            8'h08:   w_rdata = {24'b0, r_op_type};
            8'h0C:   w_rdata = 32'(r_ready);
            default: begin
                for (int c = 0; c < N_CH; c++) begin
                    if (int'(w_idx) == c) begin
                        if (periph.addr[7:5] == 3'b001 && periph.addr[1:0] == 2'b00) w_rdata = 32'(r_len[c]);
                        if (w_prog_rd)                                               w_rdata = 32'(r_cnt[c]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_start   <= 1'b0;
            r_evt     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_op_type <= '0;
            r_ready   <= '0;
            // NOTE: the register file is a handful of flops, not a RAM, so each entry is reset.
            for (int c = 0; c < N_CH; c++) begin
                r_len[c] <= '0;
                r_cnt[c] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments; later writes in this block take priority.
            r_rvalid <= periph.req;
            r_rdata  <= w_rd ? w_rdata : '0;
            r_start  <= 1'b0;
            r_evt    <= 1'b0;
            if (w_clr) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_ready <= '0;
                for (int c = 0; c < N_CH; c++) r_cnt[c] <= '0;
            end else begin
                if (w_ready_wr) r_ready <= r_ready | periph.wdata[N_CH-1:0];
                if (!r_busy && w_op_wr) r_op_type <= periph.wdata[7:0];
                for (int c = 0; c < N_CH; c++) begin
                    if (!r_busy && w_len_wr && int'(w_idx) == c) r_len[c] <= periph.wdata[CNT_WIDTH-1:0];
                    if (w_counting) r_cnt[c] <= w_cnt_nxt[c];
                end
                if (w_ovf) r_err <= 1'b1;

                case (r_state)
                    S_IDLE: if (w_trig) begin
                        r_state <= S_WAIT_RDY;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        for (int c = 0; c < N_CH; c++) r_cnt[c] <= '0;
                    end
                    S_WAIT_RDY: if (&r_ready) begin
                        r_state <= S_START;
                        r_start <= 1'b1;
                    end
                    S_START: r_state <= S_RUN;
                    S_RUN: if (w_all_done) begin
                        r_state <= S_DONE;
                        r_evt   <= 1'b1;
                        r_done  <= 1'b1;
                        // Ready flags are consumed by the job; a write landing now still sets bits.
                        r_ready <= w_ready_wr ? periph.wdata[N_CH-1:0] : '0;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase

                if (w_trig && r_busy) r_err <= 1'b1;
            end
        end
    end

    assign periph.gnt    = periph.req;
    assign periph.rdata  = r_rdata;
    assign periph.rvalid = r_rvalid;
    assign ch_start_o    = {N_CH{r_start}};
    assign evt_o         = {N_CORES{r_evt}};
    assign busy_o        = r_busy;
    assign op_type_o     = r_op_type;

endmodule
